// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
package stopwatch_pkg;

    localparam int unsigned BCD_WIDTH          = 24;
    localparam int unsigned DEBOUNCE_TICKS_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_LAP   = 3'd2,
        S_STOP  = 3'd3,
        S_CLEAR = 3'd4
    } sw_state_t;

    // CLEAR is transient and reports as IDLE on the status port
    function automatic logic [1:0] state_code(input sw_state_t s);
        return (s == S_CLEAR) ? 2'd0 : s[1:0];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debouncer emitting one pulse per qualified press.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic i_rtcclk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CW = $clog2(TICKS + 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          locked;

    always_ff @(posedge i_rtcclk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // locked: a press has fired; wait for TICKS stable-low cycles before re-arming
    always_ff @(posedge i_rtcclk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            locked <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync2 != locked) begin
                if (cnt == CW'(TICKS - 1)) begin
                    cnt    <= '0;
                    locked <= ~locked;
                    pulse  <= ~locked;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced buttons drive run/lap/stop/clear and the display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic                 i_rtcclk,
    input  logic                 rst,
    input  logic                 i_btn_startstop,
    input  logic                 i_btn_lap,
    input  logic                 i_btn_clear,
    input  logic [BCD_WIDTH-1:0] i_count,
    output logic                 o_countenb,
    output logic                 o_latchcount,
    output logic                 o_countinit,
    output logic [BCD_WIDTH-1:0] o_display,
    output logic                 o_lapfreeze,
    output logic [1:0]           o_state
);

    logic                 ss_p, lap_p, clr_p;
    sw_state_t            state_q, state_d;
    logic                 capture;
    logic [BCD_WIDTH-1:0] lap_q;

    btn_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_ss (
        .i_rtcclk(i_rtcclk), .rst(rst), .btn(i_btn_startstop), .pulse(ss_p));
    btn_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_lap (
        .i_rtcclk(i_rtcclk), .rst(rst), .btn(i_btn_lap), .pulse(lap_p));
    btn_debounce #(.TICKS(DEBOUNCE_TICKS)) u_db_clr (
        .i_rtcclk(i_rtcclk), .rst(rst), .btn(i_btn_clear), .pulse(clr_p));

    always_ff @(posedge i_rtcclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lap_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) lap_q <= i_count;
        end
    end

    // Priority startstop > lap > clear: a lap pulse masks clear even where lap itself is ignored
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ss_p)                state_d = S_RUN;
                else if (!lap_p && clr_p) state_d = S_CLEAR;
            end
            S_RUN: begin
                if (ss_p) state_d = S_STOP;
                else if (lap_p) begin
                    state_d = S_LAP;
                    capture = 1'b1;
                end
            end
            S_LAP: begin
                if (ss_p)       state_d = S_STOP;
                else if (lap_p) state_d = S_RUN;
            end
            S_STOP: begin
                if (ss_p)                state_d = S_RUN;
                else if (!lap_p && clr_p) state_d = S_CLEAR;
            end
            S_CLEAR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_countenb   = (state_q == S_RUN) || (state_q == S_LAP);
        o_latchcount = o_countenb;
        o_countinit  = (state_q == S_CLEAR);
        o_lapfreeze  = (state_q == S_LAP);
        o_display    = o_lapfreeze ? lap_q : i_count;
        o_state      = state_code(state_q);
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_TICKS=4.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss, lap, clr;
    logic [23:0] cnt_in;
    logic        countenb, latchcount, countinit, lapfreeze;
    logic [23:0] display;
    logic [1:0]  state;

    int unsigned vectors = 0;
    int unsigned errs    = 0;

    stopwatch_ctrl #(.DEBOUNCE_TICKS(4)) dut (
        .i_rtcclk       (clk),
        .rst            (rst),
        .i_btn_startstop(ss),
        .i_btn_lap      (lap),
        .i_btn_clear    (clr),
        .i_count        (cnt_in),
        .o_countenb     (countenb),
        .o_latchcount   (latchcount),
        .o_countinit    (countinit),
        .o_display      (display),
        .o_lapfreeze    (lapfreeze),
        .o_state        (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // which: 0=startstop 1=lap 2=clear; state changes on the 7th edge, then release and re-arm
    task automatic press(input int unsigned which);
        ss  = (which == 0);
        lap = (which == 1);
        clr = (which == 2);
        repeat (7) tick();
        ss = 1'b0; lap = 1'b0; clr = 1'b0;
        repeat (8) tick();
    endtask

    int unsigned ci_pulses;
    int unsigned ci_at;

    initial begin
        rst = 1'b1; ss = 1'b0; lap = 1'b0; clr = 1'b0; cnt_in = 24'h000000;
        repeat (3) tick();
        check("rst_state", state, 24'd0);
        check("rst_countenb", countenb, 24'd0);
        check("rst_latchcount", latchcount, 24'd0);
        check("rst_countinit", countinit, 24'd0);
        check("rst_lapfreeze", lapfreeze, 24'd0);
        rst = 1'b0;
        cnt_in = 24'h000042;
        tick();
        check("idle_display", display, 24'h000042);

        // short glitch: 3 cycles high never qualifies
        ss = 1'b1;
        repeat (3) tick();
        ss = 1'b0;
        repeat (10) tick();
        check("short_press_state", state, 24'd0);

        // held press: transition on edge 7 exactly once
        ss = 1'b1;
        repeat (6) tick();
        check("ss_edge6_state", state, 24'd0);
        tick();
        check("ss_edge7_state", state, 24'd1);
        check("run_countenb", countenb, 24'd1);
        check("run_latchcount", latchcount, 24'd1);
        tick();
        ss = 1'b0;
        repeat (12) tick();
        check("ss_held_once", state, 24'd1);

        press(2);
        check("clear_ignored_run", state, 24'd1);

        // lap capture and freeze
        cnt_in = 24'h012345;
        press(1);
        cnt_in = 24'h012399;
        #1;
        check("lap_state", state, 24'd2);
        check("lap_display", display, 24'h012345);
        check("lap_freeze", lapfreeze, 24'd1);
        check("lap_countenb", countenb, 24'd1);
        press(1);
        check("unlap_state", state, 24'd1);
        check("unlap_display", display, 24'h012399);
        check("unlap_freeze", lapfreeze, 24'd0);
        cnt_in = 24'h000777;
        press(1);
        cnt_in = 24'h000800;
        #1;
        check("relap_display", display, 24'h000777);
        press(0);
        check("lap_to_stop", state, 24'd3);
        check("stop_countenb", countenb, 24'd0);
        check("stop_display", display, 24'h000800);

        // clear from STOP: one-cycle countinit on edge 7, then IDLE
        ci_pulses = 0;
        ci_at = 0;
        clr = 1'b1;
        for (int unsigned i = 1; i <= 16; i++) begin
            tick();
            if (i == 7) clr = 1'b0;
            if (countinit === 1'b1) begin
                ci_pulses++;
                ci_at = i;
            end
        end
        check("countinit_pulses", 24'(ci_pulses), 24'd1);
        check("countinit_edge", 24'(ci_at), 24'd7);
        check("clear_state", state, 24'd0);
        check("clear_countenb", countenb, 24'd0);

        press(1);
        check("lap_ignored_idle", state, 24'd0);

        // simultaneous startstop + lap in RUN: startstop wins, no capture
        press(0);
        check("resume_run", state, 24'd1);
        cnt_in = 24'h055555;
        ss = 1'b1; lap = 1'b1;
        repeat (7) tick();
        ss = 1'b0; lap = 1'b0;
        repeat (8) tick();
        check("simul_state", state, 24'd3);
        check("simul_lapreg", dut.lap_q, 24'h000777);
        check("simul_display", display, 24'h055555);
        check("simul_freeze", lapfreeze, 24'd0);

        // reset in LAP with a half-qualified startstop press pending
        press(0);
        cnt_in = 24'h000321;
        press(1);
        check("lap2_display", display, 24'h000321);
        ss = 1'b1;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", state, 24'd0);
        check("async_rst_countenb", countenb, 24'd0);
        check("async_rst_freeze", lapfreeze, 24'd0);
        check("async_rst_display", display, 24'h000321);
        check("async_rst_lapreg", dut.lap_q, 24'h000000);
        tick();
        rst = 1'b0; ss = 1'b0;
        repeat (12) tick();
        check("post_rst_no_pulse", state, 24'd0);

        // button held through reset release needs full qualification
        ss = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        check("held_rst_edge6", state, 24'd0);
        tick();
        check("held_rst_edge7", state, 24'd1);
        ss = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_TICKS, default 4, number of consecutive i_rtcclk cycles a button must be stable to register (4 x 5 ms = 20 ms).
REQ-002 Port: i_rtcclk  in  1  stopwatch clock, one rising edge per 5 ms.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: i_btn_startstop  in  1  raw start/stop button, active-high, asynchronous to i_rtcclk.
REQ-005 Port: i_btn_lap  in  1  raw lap button, active-high, asynchronous.
REQ-006 Port: i_btn_clear  in  1  raw clear button, active-high, asynchronous.
REQ-007 Port: i_count  in  24  live BCD time from the counter, {tens min, min, tens sec, sec, hundreds ms, tens ms}.
REQ-008 Port: o_countenb  out  1  counter enable.
REQ-009 Port: o_latchcount  out  1  counter advance qualifier.
REQ-010 Port: o_countinit  out  1  one-cycle counter clear pulse.
REQ-011 Port: o_display  out  24  BCD value for the display driver.
REQ-012 Port: o_lapfreeze  out  1  high while o_display shows a captured lap value.
REQ-013 Port: o_state  out  2  current FSM state encoding.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer producing a one-cycle press pulse when the synchronized level has been high for DEBOUNCE_TICKS consecutive cycles.
REQ-015 A debouncer SHALL not re-arm until the synchronized level has been low for DEBOUNCE_TICKS consecutive cycles; a held button yields exactly one pulse.
REQ-016 A high level shorter than DEBOUNCE_TICKS cycles SHALL produce no pulse and SHALL restart the stability count.
REQ-017 The press pulse SHALL assert DEBOUNCE_TICKS+2 edges after the first edge sampling the raw input high; the FSM SHALL change state on the next edge (DEBOUNCE_TICKS+3 edges total).
REQ-018 FSM states: IDLE=0, RUN=1, LAP=2, STOP=3, plus a transient CLEAR state sharing IDLE's o_state encoding.
REQ-019 IDLE: startstop -> RUN; clear -> CLEAR; lap ignored.
REQ-020 RUN: startstop -> STOP; lap -> LAP, capturing i_count into the lap register on the same edge; clear ignored.
REQ-021 LAP: lap -> RUN; startstop -> STOP; clear ignored.
REQ-022 STOP: startstop -> RUN (resume, no clear); clear -> CLEAR; lap ignored.
REQ-023 CLEAR: o_countinit=1 for exactly one cycle, then unconditionally -> IDLE; all presses in that cycle discarded.
REQ-024 Simultaneous pulses SHALL be resolved with priority startstop > lap > clear; lower-priority pulses in that cycle are discarded.
REQ-025 o_countenb and o_latchcount SHALL be 1 in RUN and LAP, 0 in all other states, driven from registered state (no combinational path from buttons).
REQ-026 o_display SHALL equal the lap register and o_lapfreeze=1 in LAP; otherwise o_display=i_count and o_lapfreeze=0.
REQ-027 The lap register SHALL hold its value until the next capture; re-entering LAP from RUN always captures a fresh value.

Reset
REQ-028 On rst: state=IDLE, lap register=24'h000000, synchronizers, debounce counters and arm flags cleared, o_countenb=0, o_latchcount=0, o_countinit=0, o_lapfreeze=0, o_state=0.
REQ-029 rst asserted mid-operation (any state, any debounce count) SHALL take effect immediately and discard pending presses; a button held through reset release SHALL pulse only after full DEBOUNCE_TICKS qualification.

Structure
REQ-030 A shared package stopwatch_pkg SHALL hold the state enum, BCD_WIDTH=24, and the DEBOUNCE_TICKS default.
REQ-031 Synchronizer plus debouncer SHALL be one sub-module, btn_debounce, instantiated three times.

Verification (DEBOUNCE_TICKS=4)
REQ-032 Reset, hold startstop high 8 cycles -> o_state=1 at edge 7, o_countenb=o_latchcount=1, exactly one transition.
REQ-033 startstop high 3 cycles, low, in IDLE -> no pulse, o_state stays 0.
REQ-034 In RUN with i_count=24'h012345, press lap, then drive i_count to 24'h012399 -> o_display=24'h012345, o_lapfreeze=1; press lap again -> o_display=24'h012399.
REQ-035 In STOP, press clear -> o_countinit high exactly one cycle, then o_state=0, o_countenb=0.
REQ-036 In RUN, startstop and lap pressed on the same cycle -> STOP, lap register unchanged.
REQ-037 Assert rst for one cycle while in LAP with a half-qualified press pending -> all outputs at reset values, no press pulse afterwards.
